// File: rtl/fp_post_normalize_pkg.sv
// Shared FP32 post-normalize definitions: field sizes, raw mantissa bit positions,
// flag indices and FSM state encoding. Imported by the interface, top and rounder.
package fp_post_normalize_pkg;

  localparam int BIT_SIZE = 31;   // MSB index of packed word
  localparam int EXP_SIZE = 7;    // MSB index of exponent field
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int MANT_W   = 28;

  // Raw mantissa layout: carry, hidden, 23-bit fraction, guard, round, sticky
  localparam int CARRY_BIT  = 27;
  localparam int HIDDEN_BIT = 26;
  localparam int LSB_BIT    = 3;
  localparam int G_BIT      = 2;
  localparam int R_BIT      = 1;
  localparam int S_BIT      = 0;

  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_ZERO      = 3;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StNorm  = 2'd1;
  localparam logic [1:0] StRound = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/fp_post_normalize_if.sv
// Handshake bundle for the post-normalize stage.
//   in_*  : raw aligned sum from the adder core (valid/ready)
//   out_* : packed IEEE-754 single and flags toward the result register (valid/ready)
// master = producer/consumer side (adder core + result register), slave = this stage.
interface fp_post_normalize_if;
  import fp_post_normalize_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                in_sign;
  logic [EXP_SIZE:0]   in_exp;
  logic [MANT_W-1:0]   in_mant;
  logic                out_valid;
  logic                out_ready;
  logic [BIT_SIZE:0]   out_result;
  logic [3:0]          out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

endinterface

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even of a normalized raw mantissa.
//   mant    : raw mantissa (carry clear after normalization)
//   exp     : signed internal exponent
//   sig     : rounded {hidden, fraction[22:0]}
//   exp_rnd : exponent, bumped when rounding carries out
//   inexact : any of guard/round/sticky set before rounding
module fp_round_rne
  import fp_post_normalize_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic signed [9:0] exp,
  output logic [23:0]       sig,
  output logic signed [9:0] exp_rnd,
  output logic              inexact
);

  logic        inc;
  logic [24:0] sum;

  always_comb begin
    inexact = mant[G_BIT] | mant[R_BIT] | mant[S_BIT];
    inc     = mant[G_BIT] & (mant[R_BIT] | mant[S_BIT] | mant[LSB_BIT]);
    sum     = mant[CARRY_BIT:LSB_BIT] + 25'(inc);
    // All-ones significand rounds to 10.000..0; renormalize by one place.
    if (sum[24]) begin
      sig     = sum[24:1];
      exp_rnd = exp + 10'sd1;
    end else begin
      sig     = sum[23:0];
      exp_rnd = exp;
    end
  end

endmodule

// File: rtl/fp_post_normalize.sv
// FP32 add/sub back end: iterative 1-bit/cycle normalization, carry fix-up,
// round-to-nearest-even and packing of the raw aligned sum.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of fp_post_normalize_if (input and output handshakes)
module fp_post_normalize
  import fp_post_normalize_pkg::*;
(
  input logic                clk,
  input logic                rst,
  fp_post_normalize_if.slave bus
);

  logic [1:0]          state_q, state_d;
  logic                sign_q, sign_d;
  logic signed [9:0]   exp_q, exp_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic [BIT_SIZE:0]   result_q, result_d;
  logic [3:0]          flags_q, flags_d;

  logic [23:0]         rnd_sig;
  logic signed [9:0]   rnd_exp;
  logic                rnd_inexact;
  logic [EXP_SIZE:0]   exp_field;

  fp_round_rne u_round (
    .mant    (mant_q),
    .exp     (exp_q),
    .sig     (rnd_sig),
    .exp_rnd (rnd_exp),
    .inexact (rnd_inexact)
  );

  assign bus.in_ready   = (state_q == StIdle) && !rst;
  assign bus.out_valid  = (state_q == StDone);
  assign bus.out_result = result_q;
  assign bus.out_flags  = flags_q;

  // A clear hidden bit after normalization means a denormal: field encodes as 0.
  assign exp_field = rnd_sig[23] ? rnd_exp[EXP_SIZE:0] : '0;

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sign_d  = bus.in_sign;
          // Denormal operand: exponent 1 with hidden bit clear.
          exp_d   = (bus.in_exp == '0) ? 10'sd1 : $signed({2'b00, bus.in_exp});
          mant_d  = bus.in_mant;
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (mant_q == '0) begin
          state_d = StRound;
        end else if (mant_q[CARRY_BIT]) begin
          // Shifted-out bit folds into sticky.
          mant_d  = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
          exp_d   = exp_q + 10'sd1;
          state_d = StRound;
        end else if (mant_q[HIDDEN_BIT] || exp_q <= 10'sd1) begin
          state_d = StRound;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - 10'sd1;
        end
      end
      StRound: begin
        flags_d = '0;
        if (rnd_exp >= $signed(10'(EXP_MAX))) begin
          result_d                = {sign_q, 8'hFF, 23'h0};
          flags_d[FLAG_OVERFLOW]  = 1'b1;
          flags_d[FLAG_INEXACT]   = 1'b1;
        end else begin
          result_d                = {sign_q, exp_field, rnd_sig[22:0]};
          flags_d[FLAG_INEXACT]   = rnd_inexact;
          flags_d[FLAG_UNDERFLOW] = rnd_inexact && (exp_field == '0);
          flags_d[FLAG_ZERO]      = ({exp_field, rnd_sig[22:0]} == '0);
        end
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_post_normalize.sv
module tb_fp_post_normalize;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  fp_post_normalize_if bus ();

  fp_post_normalize dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one operand, measure edges to out_valid, check result, optionally stall
  // the consumer for hold cycles, then accept and check the return to idle.
  task automatic run_op(input string tag, input logic sign, input logic [7:0] exp,
                        input logic [27:0] mant, input logic [31:0] exp_res,
                        input logic [3:0] exp_flags, input int exp_lat, input int hold);
    int waits;
    int edges;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign  = sign;
    bus.in_exp   = exp;
    bus.in_mant  = mant;
    waits = 0;
    while (!bus.in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    edges = 0;
    while (!bus.out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check_eq({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    check_eq({tag, "_result"}, bus.out_result, exp_res);
    check_eq({tag, "_flags"}, 32'(bus.out_flags), 32'(exp_flags));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check_eq({tag, "_hold_result"}, bus.out_result, exp_res);
      check_eq({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_result", bus.out_result, 32'h0);
    check_eq("rst_out_flags", 32'(bus.out_flags), 32'h0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_release_ready", 32'(bus.in_ready), 32'd1);

    run_op("t1_one", 1'b0, 8'd127, 28'h4000000, 32'h3F800000, 4'b0000, 2, 0);
    run_op("t2_carry", 1'b0, 8'd127, 28'h8000000, 32'h40000000, 4'b0000, 2, 0);
    run_op("t2_ovf", 1'b0, 8'd254, 28'h8000000, 32'h7F800000, 4'b0101, 2, 0);
    run_op("t3_shift", 1'b0, 8'd130, 28'h0000008, 32'h35800000, 4'b0000, 25, 0);
    run_op("t4_tie_even", 1'b0, 8'd127, 28'h4000004, 32'h3F800000, 4'b0001, 2, 0);
    run_op("t4_tie_odd", 1'b0, 8'd127, 28'h400000C, 32'h3F800002, 4'b0001, 2, 0);
    // Result magnitude rounds to 0: inexact, underflow and zero all set.
    run_op("t4_denorm", 1'b0, 8'd0, 28'h0000004, 32'h00000000, 4'b1011, 2, 0);
    run_op("t5_zero", 1'b1, 8'd127, 28'h0000000, 32'h80000000, 4'b1000, 2, 5);

    // Reset in the middle of the long normalization of test 3.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b0;
    bus.in_exp   = 8'd130;
    bus.in_mant  = 28'h0000008;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t6_release_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check_eq("t6_no_result", 32'(seen), 32'd0);
    run_op("t6_after", 1'b0, 8'd127, 28'h4000000, 32'h3F800000, 4'b0000, 2, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
